// File: rtl/decode_pipe_stage_if.sv
// Bundle of the fetch-side, write-back, execute-stage and pipeline-register
// signals of the decode stage. The master drives the inputs and the slave
// (the decode stage) drives the registered outputs.
interface decode_pipe_stage_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int INSTR_WIDTH = 16,
  parameter int CTRL_WIDTH  = 24
);
  logic                   i_valid;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [CTRL_WIDTH-1:0]  i_ctrl;
  logic                   i_read1;
  logic                   i_read2;
  logic                   i_stall;
  logic                   i_flush;
  logic                   i_write_back;
  logic [ADDR_WIDTH-1:0]  i_write_addr;
  logic [DATA_WIDTH-1:0]  i_write_data;
  logic                   i_ex_valid;
  logic                   i_ex_mem_read;
  logic [ADDR_WIDTH-1:0]  i_ex_rd;
  logic                   o_ready;
  logic                   o_hazard;
  logic                   o_valid;
  logic [CTRL_WIDTH-1:0]  o_ctrl;
  logic [DATA_WIDTH-1:0]  o_data1;
  logic [DATA_WIDTH-1:0]  o_data2;
  logic [ADDR_WIDTH-1:0]  o_rd;
  logic [ADDR_WIDTH-1:0]  o_rs;

  modport master (
    output i_valid, i_instr, i_ctrl, i_read1, i_read2, i_stall, i_flush,
           i_write_back, i_write_addr, i_write_data,
           i_ex_valid, i_ex_mem_read, i_ex_rd,
    input  o_ready, o_hazard, o_valid, o_ctrl, o_data1, o_data2, o_rd, o_rs
  );

  modport slave (
    input  i_valid, i_instr, i_ctrl, i_read1, i_read2, i_stall, i_flush,
           i_write_back, i_write_addr, i_write_data,
           i_ex_valid, i_ex_mem_read, i_ex_rd,
    output o_ready, o_hazard, o_valid, o_ctrl, o_data1, o_data2, o_rd, o_rs
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode stage: architectural register file with write-back bypass on both
// read ports, load-use hazard detection against execute, and the
// decode/execute pipeline register with flush, stall and bubble controls.
module decode_pipe_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int REG_COUNT   = 8,
  parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int INSTR_WIDTH = 16,
  parameter int RD_LSB      = 8,
  parameter int RS_LSB      = 5,
  parameter int CTRL_WIDTH  = 24
) (
  input logic                i_clk,
  input logic                i_reset,
  decode_pipe_stage_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  hazard;

  logic                  valid_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [DATA_WIDTH-1:0] data2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] rs_q;
  // Read enables of the held instruction, needed to refresh operands that
  // get written back while the instruction is stalled.
  logic                  read1_q;
  logic                  read2_q;

  // Instruction bits outside the rd/rs fields are decoded by the external
  // control unit.
  logic unused_instr;
  assign unused_instr = ^bus.i_instr;

  assign rd_addr = bus.i_instr[RD_LSB +: ADDR_WIDTH];
  assign rs_addr = bus.i_instr[RS_LSB +: ADDR_WIDTH];

  // Register file write; never blocked by stall, flush or hazard.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (bus.i_write_back) begin
      regs[bus.i_write_addr] <= bus.i_write_data;
    end
  end

  // Operand read with same-cycle write-back bypass; disabled ports read 0.
  always_comb begin
    data1 = '0;
    data2 = '0;
    if (bus.i_read1) begin
      if (bus.i_write_back && (bus.i_write_addr == rd_addr)) data1 = bus.i_write_data;
      else                                                   data1 = regs[rd_addr];
    end
    if (bus.i_read2) begin
      if (bus.i_write_back && (bus.i_write_addr == rs_addr)) data2 = bus.i_write_data;
      else                                                   data2 = regs[rs_addr];
    end
  end

  // Load-use hazard: the load in execute has not produced its data yet.
  always_comb begin
    hazard = bus.i_valid && bus.i_ex_valid && bus.i_ex_mem_read &&
             ((bus.i_read1 && (rd_addr == bus.i_ex_rd)) ||
              (bus.i_read2 && (rs_addr == bus.i_ex_rd)));
  end

  // Pipeline register: flush, then stall (with write-back refresh), then
  // bubble on hazard, otherwise capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      read1_q <= 1'b0;
      read2_q <= 1'b0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (bus.i_stall) begin
      if (valid_q && bus.i_write_back) begin
        if (read1_q && (rd_q == bus.i_write_addr)) data1_q <= bus.i_write_data;
        if (read2_q && (rs_q == bus.i_write_addr)) data2_q <= bus.i_write_data;
      end
    end else if (hazard) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= bus.i_valid;
      ctrl_q  <= bus.i_valid ? bus.i_ctrl : '0;
      data1_q <= data1;
      data2_q <= data2;
      rd_q    <= rd_addr;
      rs_q    <= rs_addr;
      read1_q <= bus.i_read1;
      read2_q <= bus.i_read2;
    end
  end

  assign bus.o_hazard = hazard;
  assign bus.o_ready  = !hazard && !bus.i_stall;
  assign bus.o_valid  = valid_q;
  assign bus.o_ctrl   = ctrl_q;
  assign bus.o_data1  = data1_q;
  assign bus.o_data2  = data2_q;
  assign bus.o_rd     = rd_q;
  assign bus.o_rs     = rs_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: instance A uses default parameters
// with a scoreboard of expected pipeline-register contents; instance B uses
// 32-bit data and 16 registers.
module tb_decode_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  decode_pipe_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .INSTR_WIDTH(16), .CTRL_WIDTH(24)) bus_a ();
  decode_pipe_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .INSTR_WIDTH(16), .CTRL_WIDTH(24)) bus_b ();

  decode_pipe_stage #(.DATA_WIDTH(16), .REG_COUNT(8)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_a)
  );

  decode_pipe_stage #(.DATA_WIDTH(32), .REG_COUNT(16)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_b)
  );

  typedef struct packed {
    logic        v;
    logic [23:0] ctrl;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  rd;
    logic [2:0]  rs;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic v, input logic [23:0] ctrl, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [2:0] rd, input logic [2:0] rs);
    exp_t e;
    e.v = v; e.ctrl = ctrl; e.d1 = d1; e.d2 = d2; e.rd = rd; e.rs = rs;
    sb.push_back(e);
  endtask

  // Advance one clock, then pop the oldest expectation and compare instance A.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(bus_a.o_valid), 64'(e.v));
      chk({tag, "_ctrl"},  64'(bus_a.o_ctrl),  64'(e.ctrl));
      chk({tag, "_data1"}, 64'(bus_a.o_data1), 64'(e.d1));
      chk({tag, "_data2"}, 64'(bus_a.o_data2), 64'(e.d2));
      chk({tag, "_rd"},    64'(bus_a.o_rd),    64'(e.rd));
      chk({tag, "_rs"},    64'(bus_a.o_rs),    64'(e.rs));
    end
  endtask

  function automatic logic [15:0] ins_a(input int rd, input int rs);
    return 16'((rd << 8) | (rs << 5));
  endfunction

  task automatic idle_a();
    bus_a.i_valid = 0; bus_a.i_instr = '0; bus_a.i_ctrl = '0;
    bus_a.i_read1 = 0; bus_a.i_read2 = 0; bus_a.i_stall = 0; bus_a.i_flush = 0;
    bus_a.i_write_back = 0; bus_a.i_write_addr = '0; bus_a.i_write_data = '0;
    bus_a.i_ex_valid = 0; bus_a.i_ex_mem_read = 0; bus_a.i_ex_rd = '0;
  endtask

  task automatic idle_b();
    bus_b.i_valid = 0; bus_b.i_instr = '0; bus_b.i_ctrl = '0;
    bus_b.i_read1 = 0; bus_b.i_read2 = 0; bus_b.i_stall = 0; bus_b.i_flush = 0;
    bus_b.i_write_back = 0; bus_b.i_write_addr = '0; bus_b.i_write_data = '0;
    bus_b.i_ex_valid = 0; bus_b.i_ex_mem_read = 0; bus_b.i_ex_rd = '0;
  endtask

  task automatic wb_a(input int addr, input logic [15:0] data);
    bus_a.i_write_back = 1; bus_a.i_write_addr = 3'(addr); bus_a.i_write_data = data;
  endtask

  task automatic dec_a(input int rd, input int rs, input logic r1, input logic r2,
                       input logic [23:0] ctrl);
    bus_a.i_valid = 1; bus_a.i_instr = ins_a(rd, rs);
    bus_a.i_read1 = r1; bus_a.i_read2 = r2; bus_a.i_ctrl = ctrl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_a();
    idle_b();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus_a.o_valid), 64'd0);
    chk("rst_ctrl",  64'(bus_a.o_ctrl),  64'd0);
    chk("rst_data1", 64'(bus_a.o_data1), 64'd0);
    chk("rst_ready", 64'(bus_a.o_ready), 64'd1);
    rst_n = 1'b1;

    // Preload R3, confirm it is there, then reset and confirm it cleared.
    wb_a(3, 16'h5555);
    push(0, 24'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    step("preload_wr");
    idle_a();
    dec_a(3, 0, 1, 0, 24'hA5A5A5);
    push(1, 24'hA5A5A5, 16'h5555, 16'h0, 3'd3, 3'd0);
    step("preload_rd");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus_a.o_valid), 64'd0);
    chk("async_rst_data1", 64'(bus_a.o_data1), 64'd0);
    chk("async_rst_rd",    64'(bus_a.o_rd),    64'd0);
    #1 rst_n = 1'b1;
    chk("post_rst_ready", 64'(bus_a.o_ready), 64'd1);
    push(1, 24'hA5A5A5, 16'h0, 16'h0, 3'd3, 3'd0);
    step("r3_cleared");

    // Same-cycle write-back bypass on rd.
    idle_a();
    wb_a(2, 16'h1234);
    dec_a(2, 3, 1, 1, 24'h111111);
    push(1, 24'h111111, 16'h1234, 16'h0, 3'd2, 3'd3);
    step("bypass");

    // R2 stored; read enable 1 off forces operand 1 to 0; write R5.
    idle_a();
    wb_a(5, 16'h0BAD);
    dec_a(6, 2, 0, 1, 24'h222222);
    push(1, 24'h222222, 16'h0, 16'h1234, 3'd6, 3'd2);
    step("read_gate");

    // Load-use hazard on rs=5.
    idle_a();
    bus_a.i_ex_valid = 1; bus_a.i_ex_mem_read = 1; bus_a.i_ex_rd = 3'd5;
    dec_a(1, 5, 1, 0, 24'h333333);
    #1;
    chk("no_hazard_unread", 64'(bus_a.o_hazard), 64'd0);
    bus_a.i_read2 = 1;
    #1;
    chk("hazard", 64'(bus_a.o_hazard), 64'd1);
    chk("hazard_ready", 64'(bus_a.o_ready), 64'd0);
    push(0, 24'h0, 16'h0, 16'h1234, 3'd6, 3'd2);
    step("bubble");
    bus_a.i_ex_mem_read = 0;
    #1;
    chk("hazard_clear", 64'(bus_a.o_hazard), 64'd0);
    chk("hazard_clear_ready", 64'(bus_a.o_ready), 64'd1);
    push(1, 24'h333333, 16'h0, 16'h0BAD, 3'd1, 3'd5);
    step("after_hazard");

    // Stall three cycles with rd=4 held; write R4 (refresh) and R1 (rs not read).
    idle_a();
    dec_a(4, 1, 1, 0, 24'h444444);
    push(1, 24'h444444, 16'h0, 16'h0, 3'd4, 3'd1);
    step("pre_stall");
    bus_a.i_stall = 1;
    bus_a.i_ctrl = 24'h999999;
    #1;
    chk("stall_ready", 64'(bus_a.o_ready), 64'd0);
    push(1, 24'h444444, 16'h0, 16'h0, 3'd4, 3'd1);
    step("stall1");
    wb_a(4, 16'hBEEF);
    push(1, 24'h444444, 16'hBEEF, 16'h0, 3'd4, 3'd1);
    step("stall2_refresh");
    wb_a(1, 16'h7777);
    push(1, 24'h444444, 16'hBEEF, 16'h0, 3'd4, 3'd1);
    step("stall3_noread");
    idle_a();
    dec_a(4, 1, 1, 0, 24'h444444);
    push(1, 24'h444444, 16'hBEEF, 16'h0, 3'd4, 3'd1);
    step("stall_release");

    // Flush wins over stall; the concurrent write still lands.
    idle_a();
    bus_a.i_flush = 1; bus_a.i_stall = 1;
    wb_a(6, 16'h6666);
    dec_a(6, 0, 1, 0, 24'hCCCCCC);
    #1;
    chk("flush_stall_ready", 64'(bus_a.o_ready), 64'd0);
    push(0, 24'h0, 16'hBEEF, 16'h0, 3'd4, 3'd1);
    step("flush_stall");
    idle_a();
    dec_a(6, 0, 1, 0, 24'h555555);
    push(1, 24'h555555, 16'h6666, 16'h0, 3'd6, 3'd0);
    step("flush_write_landed");
    idle_a();

    // Instance B: 32-bit data, 16 registers; R15 read through rs.
    bus_b.i_write_back = 1; bus_b.i_write_addr = 4'd15; bus_b.i_write_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    idle_b();
    bus_b.i_valid = 1;
    bus_b.i_instr = 16'h01E0;
    bus_b.i_read2 = 1;
    bus_b.i_ctrl = 24'h0F0F0F;
    @(posedge clk);
    #1;
    chk("b_valid", 64'(bus_b.o_valid), 64'd1);
    chk("b_data2", 64'(bus_b.o_data2), 64'hFFFFFFFF);
    chk("b_rs",    64'(bus_b.o_rs),    64'd15);
    chk("b_rd",    64'(bus_b.o_rd),    64'd1);
    chk("b_data1", 64'(bus_b.o_data1), 64'd0);
    chk("b_ctrl",  64'(bus_b.o_ctrl),  64'h0F0F0F);
    idle_b();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Parametrised decode stage with an integrated pipeline output register. It holds the architectural register file, reads two operands with same-cycle write-back bypass, and detects load-use hazards against the execute stage. The decoded control bus and operands are registered into the decode/execute pipeline register, which has valid, stall, flush and bubble-insertion controls. The block sits between fetch and execute. The control unit stays external and drives i_ctrl, i_read1 and i_read2.

Parameters:
DATA_WIDTH, 16, register and operand width
REG_COUNT, 8, number of architectural registers (power of two, >= 2)
ADDR_WIDTH, $clog2(REG_COUNT), register address width
INSTR_WIDTH, 16, instruction width
RD_LSB, 8, LSB of the rd field in i_instr (field is ADDR_WIDTH bits)
RS_LSB, 5, LSB of the rs field in i_instr
CTRL_WIDTH, 24, width of the packed control bus

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  i_instr holds a valid instruction
i_instr  in  INSTR_WIDTH  instruction from fetch
i_ctrl  in  CTRL_WIDTH  packed control-unit outputs for i_instr
i_read1  in  1  instruction reads rd
i_read2  in  1  instruction reads rs
i_stall  in  1  downstream hold request
i_flush  in  1  squash request (branch/interrupt)
i_write_back  in  1  write-back enable
i_write_addr  in  ADDR_WIDTH  write-back register
i_write_data  in  DATA_WIDTH  write-back data
i_ex_valid  in  1  execute stage holds a valid instruction
i_ex_mem_read  in  1  execute-stage instruction is a load
i_ex_rd  in  ADDR_WIDTH  execute-stage destination
o_ready  out  1  fetch may advance: ~o_hazard & ~i_stall
o_hazard  out  1  load-use hazard, combinational
o_valid  out  1  pipeline register valid
o_ctrl  out  CTRL_WIDTH  registered control bus
o_data1  out  DATA_WIDTH  registered operand 1 (rd)
o_data2  out  DATA_WIDTH  registered operand 2 (rs)
o_rd  out  ADDR_WIDTH  registered rd
o_rs  out  ADDR_WIDTH  registered rs

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All REG_COUNT registers clear to 0.
  - o_valid, o_ctrl, o_data1, o_data2, o_rd and o_rs all clear to 0.
- Register file writes:
  - Performed on the rising edge when i_write_back=1.
  - Every index is writable; no hard-wired zero register.
  - Writes are never blocked by stall, flush or hazard.
- Operand read (combinational, per port):
  - If the port's read enable is 0: value is 0.
  - Else if i_write_back=1 and i_write_addr equals the read address: value is i_write_data (bypass).
  - Else: value is the register contents.
- o_hazard = i_valid & i_ex_valid & i_ex_mem_read & ((i_read1 & rd==i_ex_rd) | (i_read2 & rs==i_ex_rd)).
- Pipeline register update each rising edge, in priority order:
  1. i_flush=1: o_valid<=0, o_ctrl<=0. Data and address outputs are don't-care; implement as hold.
  2. i_stall=1: hold all outputs, with refresh. If o_valid=1, i_write_back=1, and the held rd (or rs) was read and equals i_write_addr, load i_write_data into o_data1 (or o_data2). The stored read enables are kept internally for this check.
  3. o_hazard=1: insert a bubble: o_valid<=0, o_ctrl<=0.
  4. Otherwise capture: o_valid<=i_valid, and load the bypassed operands, the rd/rs fields and i_ctrl. If i_valid=0, o_ctrl<=0.
- Latency: one cycle from i_instr to the registered outputs.
- A stalled instruction remains presented to fetch until o_ready=1. Fetch must hold i_instr while o_ready=0.
- Flush and stall together: flush wins. o_ready still follows its equation.
- A hazard lasts exactly as long as the load sits in execute. The next cycle captures normally.

Test Plan:
- Reset with registers preloaded, then release -> all outputs 0, o_valid=0, o_ready=1; a read of R3 returns 0.
- Write R2=0x1234 and, in the same cycle, decode an instruction reading rd=2 -> next cycle o_data1=0x1234 (bypass), o_valid=1.
- i_ex_valid=1, i_ex_mem_read=1, i_ex_rd=5; decode an instruction with rs=5, i_read2=1 -> o_hazard=1, o_ready=0, next o_valid=0 and o_ctrl=0. Drop i_ex_mem_read -> the instruction is captured on the following cycle.
- Hold i_stall=1 for 3 cycles with o_valid=1 and held rd=4; write R4=0xBEEF during the stall -> o_data1 becomes 0xBEEF while all other outputs are unchanged.
- Assert i_flush and i_stall together -> next o_valid=0, o_ctrl=0; a register write in the same cycle still lands.
- REG_COUNT=16, DATA_WIDTH=32: write R15=0xFFFFFFFF, read it via rs -> o_data2=0xFFFFFFFF and o_rs=15.
